// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding and frame geometry for the serial ADC sampler.
package adc_pkg;
    typedef enum logic [1:0] {IDLE, QUIET, SHIFT, DONE} adc_state_t;
    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
endpackage

// File: rtl/adc_spi_sampler_if.sv
// adc_spi_sampler_if: control, SPI pins and sample output of the ADC sampler.
interface adc_spi_sampler_if;
    logic               enable;
    logic               sdata;
    logic               sclk;
    logic               cs_n;
    logic signed [15:0] raw_adc_data;
    logic               data_valid;
    logic               busy;
    logic               frame_err;
    logic               overrun;
    modport master (
        input  enable, sdata,
        output sclk, cs_n, raw_adc_data, data_valid, busy, frame_err, overrun
    );
    modport slave (
        output enable, sdata,
        input  sclk, cs_n, raw_adc_data, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK half-period timing; flags each half end and the sampling point.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    output logic sample_en_o,
    output logic toggle_o
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt_q;
    logic         high_q;
    assign toggle_o    = active_i && cnt_q == W'(CLK_DIV - 1);
    assign sample_en_o = toggle_o && !high_q;
    always_ff @(posedge clk) begin
        if (reset || !active_i) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else begin
            cnt_q  <= toggle_o ? '0 : cnt_q + 1'b1;
            high_q <= toggle_o ? !high_q : high_q;
        end
    end
endmodule

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic AD7476-style SPI read, presenting each 12-bit code
// as a non-negative 16-bit word with a one-cycle valid strobe.
module adc_spi_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1250,
    parameter int QUIET_CYCLES  = 8
) (
    input logic                clk,
    input logic                reset,
    adc_spi_sampler_if.master  bus
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(QUIET_CYCLES + FRAME_BITS + 1);

    generate
        if (CLK_DIV < 2 || QUIET_CYCLES < 1 ||
            SAMPLE_PERIOD <= 32 * CLK_DIV + QUIET_CYCLES + 2) begin : g_bad_params
            $error("adc_spi_sampler: invalid CLK_DIV/QUIET_CYCLES/SAMPLE_PERIOD");
        end
    endgenerate

    adc_state_t         state_q;
    logic [TW-1:0]      tmr_q;
    logic [CW-1:0]      cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic               sclk_q, cs_n_q, dv_q, busy_q, ferr_q, ovr_q;
    logic signed [15:0] raw_q;
    logic               trigger, sample_en, toggle, high_end;

    assign trigger  = bus.enable && tmr_q == TW'(SAMPLE_PERIOD - 1);
    assign high_end = toggle && !sample_en;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .active_i   (state_q == SHIFT),
        .sample_en_o(sample_en),
        .toggle_o   (toggle)
    );

    always_ff @(posedge clk) begin
        if (reset) tmr_q <= '0;
        else       tmr_q <= (tmr_q == TW'(SAMPLE_PERIOD - 1)) ? '0 : tmr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            raw_q   <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (trigger && busy_q) ovr_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q <= QUIET;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                QUIET: begin
                    if (cnt_q == CW'(QUIET_CYCLES - 1)) begin
                        state_q <= SHIFT;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (sample_en) shift_q <= {shift_q[FRAME_BITS-2:0], bus.sdata};
                    // cnt_q counts completed bits; the last high half closes the frame
                    if (high_end && cnt_q == CW'(FRAME_BITS - 1)) begin
                        state_q <= DONE;
                        cs_n_q  <= 1'b1;
                        sclk_q  <= 1'b1;
                        raw_q   <= {{LEAD_ZEROS{1'b0}}, shift_q[ADC_BITS-1:0]};
                        ferr_q  <= |shift_q[FRAME_BITS-1:ADC_BITS];
                        dv_q    <= 1'b1;
                    end else begin
                        sclk_q <= toggle ? !sclk_q : sclk_q;
                        cnt_q  <= high_end ? cnt_q + 1'b1 : cnt_q;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sclk         = sclk_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.raw_adc_data = raw_q;
    assign bus.data_valid   = dv_q;
    assign bus.busy         = busy_q;
    assign bus.frame_err    = ferr_q;
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: directed frames against a serial ADC model driving sdata.
module tb_adc_spi_sampler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] frm = 16'h0000;
    int   idx = 0;

    adc_spi_sampler_if bus ();

    adc_spi_sampler dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #4 clk = !clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: bit idx is presented from CS fall; advances on each SCLK rise
    always @(posedge bus.sclk or posedge bus.cs_n) idx <= bus.cs_n ? 0 : idx + 1;
    assign bus.sdata = (bus.cs_n || idx > 15) ? 1'b0 : frm[15 - idx];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] f, output logic [15:0] d, output logic fe,
                             output int lat, output int csl, output int dvc, output bit ok);
        int k;
        d = '0; fe = 1'b0; lat = 0; csl = 0; dvc = 0; ok = 1'b0;
        frm = f;
        k = 0;
        while (bus.busy && k < 300) begin tick(); k++; end
        k = 0;
        while (!bus.busy && k < 1400) begin tick(); k++; end
        if (!bus.busy) return;
        while (!bus.data_valid && lat < 300) begin
            if (!bus.cs_n) csl++;
            tick();
            lat++;
        end
        ok  = bus.data_valid;
        d   = bus.raw_adc_data;
        fe  = bus.frame_err;
        dvc = cyc;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        bus.enable = 1'b0;
        repeat (3) tick();
        n_chk++; if (bus.sclk !== 1'b1) begin n_fail++; $display("FAIL rst_sclk: got %b expected 1", bus.sclk); end
        n_chk++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b expected 1", bus.cs_n); end
        n_chk++; if (bus.raw_adc_data !== 16'h0000) begin n_fail++; $display("FAIL rst_raw: got %h expected 0000", bus.raw_adc_data); end
        n_chk++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b expected 0", bus.data_valid); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr: got %b expected 0", bus.frame_err); end
        n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b expected 0", bus.overrun); end
        reset = 1'b0;
        bad = 0;
        repeat (2000) begin
            tick();
            if (bus.sclk !== 1'b1 || bus.cs_n !== 1'b1 || bus.raw_adc_data !== 16'h0000 ||
                bus.data_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL idle_disabled: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_basic_frame();
        logic [15:0] d; logic fe; int lat, csl, dv1, dv2; bit ok;
        bus.enable = 1'b1;
        run_frame(16'h0ABC, d, fe, lat, csl, dv1, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL abc_timeout: got no data_valid expected one"); end
        n_chk++; if (d !== 16'h0ABC) begin n_fail++; $display("FAIL abc_data: got %h expected 0abc", d); end
        n_chk++; if (fe !== 1'b0) begin n_fail++; $display("FAIL abc_ferr: got %b expected 0", fe); end
        n_chk++; if (lat != 136) begin n_fail++; $display("FAIL abc_latency: got %0d expected 136 after busy rise", lat); end
        n_chk++; if (csl != 128) begin n_fail++; $display("FAIL abc_cs_low: got %0d expected 128", csl); end
        tick();
        n_chk++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL abc_pulse: got %b expected 0", bus.data_valid); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abc_busy_end: got %b expected 0", bus.busy); end
        run_frame(16'h0ABC, d, fe, lat, csl, dv2, ok);
        n_chk++; if (!ok || d !== 16'h0ABC) begin n_fail++; $display("FAIL abc_repeat: got %h ok=%0d expected 0abc", d, ok); end
        n_chk++; if (dv2 - dv1 != 1250) begin n_fail++; $display("FAIL abc_period: got %0d expected 1250", dv2 - dv1); end
    endtask

    task automatic test_extremes();
        logic [15:0] d; logic fe; int lat, csl, dvc; bit ok;
        run_frame(16'h0FFF, d, fe, lat, csl, dvc, ok);
        n_chk++; if (!ok || d !== 16'h0FFF) begin n_fail++; $display("FAIL fff_data: got %h expected 0fff", d); end
        n_chk++; if (d[15] !== 1'b0) begin n_fail++; $display("FAIL fff_sign: got %b expected 0", d[15]); end
        run_frame(16'h0000, d, fe, lat, csl, dvc, ok);
        n_chk++; if (!ok || d !== 16'h0000) begin n_fail++; $display("FAIL zero_data: got %h expected 0000", d); end
    endtask

    task automatic test_frame_err();
        logic [15:0] d; logic fe; int lat, csl, dvc; bit ok;
        run_frame(16'h4123, d, fe, lat, csl, dvc, ok);
        n_chk++; if (!ok || d !== 16'h0123) begin n_fail++; $display("FAIL ferr_data: got %h expected 0123", d); end
        n_chk++; if (fe !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b expected 1", fe); end
        repeat (10) tick();
        n_chk++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_hold: got %b expected 1", bus.frame_err); end
        run_frame(16'h0456, d, fe, lat, csl, dvc, ok);
        n_chk++; if (!ok || d !== 16'h0456) begin n_fail++; $display("FAIL clean_data: got %h expected 0456", d); end
        n_chk++; if (fe !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", fe); end
    endtask

    task automatic test_enable_drop();
        int k, act;
        frm = 16'h0789;
        k = 0; while (bus.busy && k < 300) begin tick(); k++; end
        k = 0; while (bus.cs_n && k < 1400) begin tick(); k++; end
        n_chk++; if (bus.cs_n !== 1'b0) begin n_fail++; $display("FAIL drop_start: got cs_n=%b expected 0", bus.cs_n); end
        repeat (20) tick();
        bus.enable = 1'b0;
        k = 0; while (!bus.data_valid && k < 200) begin tick(); k++; end
        n_chk++; if (bus.data_valid !== 1'b1 || bus.raw_adc_data !== 16'h0789) begin
            n_fail++; $display("FAIL drop_complete: got dv=%b data=%h expected dv=1 data=0789", bus.data_valid, bus.raw_adc_data);
        end
        tick(); tick();
        act = 0;
        repeat (3000) begin
            tick();
            if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0 || bus.data_valid !== 1'b0) act++;
        end
        n_chk++; if (act != 0) begin n_fail++; $display("FAIL drop_quiet: got %0d active cycles expected 0", act); end
        n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL drop_ovr: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d; logic fe; int k, lat, csl, dvc; bit ok;
        bus.enable = 1'b1;
        frm = 16'h0321;
        k = 0; while (bus.cs_n && k < 1400) begin tick(); k++; end
        n_chk++; if (bus.cs_n !== 1'b0) begin n_fail++; $display("FAIL mid_start: got cs_n=%b expected 0", bus.cs_n); end
        repeat (50) tick();
        reset = 1'b1;
        tick();
        n_chk++; if (bus.cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_cs_n: got %b expected 1", bus.cs_n); end
        n_chk++; if (bus.sclk !== 1'b1) begin n_fail++; $display("FAIL mid_sclk: got %b expected 1", bus.sclk); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dv: got %b expected 0", bus.data_valid); end
        n_chk++; if (bus.raw_adc_data !== 16'h0000) begin n_fail++; $display("FAIL mid_raw: got %h expected 0000", bus.raw_adc_data); end
        tick();
        reset = 1'b0;
        run_frame(16'h0F0F, d, fe, lat, csl, dvc, ok);
        n_chk++; if (!ok || d !== 16'h0F0F) begin n_fail++; $display("FAIL resume_data: got %h expected 0f0f", d); end
        n_chk++; if (lat != 136 || fe !== 1'b0) begin n_fail++; $display("FAIL resume_timing: got lat=%0d fe=%b expected 136/0", lat, fe); end
    endtask

    initial begin
        bus.enable = 1'b0;
        test_reset();
        test_basic_frame();
        test_extremes();
        test_frame_err();
        test_enable_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
